// File: rtl/fifo_read_ctrl.sv
// rtl/fifo_read_ctrl.sv - burst-framing FIFO read controller with 2-entry skid buffer
module fifo_read_ctrl #(
    parameter int DATASIZE  = 8,
    parameter int BURST_LEN = 4
) (
    input  logic                rclk,
    input  logic                r_rst,
    input  logic                enable,
    input  logic                empty,
    input  logic [DATASIZE-1:0] rdata,
    output logic                rinc,
    output logic [DATASIZE-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
    output logic                busy,
    output logic [15:0]         rd_count
);

    localparam int BW = $clog2(BURST_LEN);
    localparam logic [BW-1:0] BEAT_MAX = BW'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                state_q;
    logic [BW-1:0]         beat_q, beat_d;
    logic [1:0]            occ_q, occ_d;
    logic [15:0]           rd_count_q, rd_count_d;
    logic [DATASIZE-1:0]   data0_q, data0_d, data1_q, data1_d;
    logic                  last0_q, last0_d, last1_q, last1_d;
    logic                  pop;
    logic                  xfer;
    logic                  last_in;

    // Pop decision uses only registered state plus the FIFO empty flag; reset
    // blocks it so an asserted reset never consumes a FIFO word.
    always_comb begin
        pop = r_rst && (state_q != IDLE) && !empty && (occ_q != 2'd2)
              && !((state_q == FLUSH) && (beat_q == '0));
    end

    assign rinc      = pop;
    assign out_valid = r_rst && (occ_q != 2'd0);
    assign out_data  = out_valid ? data0_q : '0;
    assign out_last  = out_valid && last0_q;
    assign busy      = r_rst && ((state_q != IDLE) || (occ_q != 2'd0));
    assign rd_count  = rd_count_q;
    assign xfer      = out_valid && out_ready;
    assign last_in   = (beat_q == BEAT_MAX);

    // Beat position and pop counter advance with every pop.
    always_comb begin
        beat_d     = beat_q;
        rd_count_d = rd_count_q + 16'(pop);
        if (pop) begin
            beat_d = last_in ? '0 : beat_q + 1'b1;
        end
    end

    // Skid buffer: slot 0 is the head; incoming words fill behind it.
    always_comb begin
        data0_d = data0_q;
        data1_d = data1_q;
        last0_d = last0_q;
        last1_d = last1_q;
        occ_d   = occ_q;
        case ({pop, xfer})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    data0_d = rdata;
                    last0_d = last_in;
                end else begin
                    data1_d = rdata;
                    last1_d = last_in;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                data0_d = data1_q;
                last0_d = last1_q;
                occ_d   = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    data0_d = rdata;
                    last0_d = last_in;
                end else begin
                    data0_d = data1_q;
                    last0_d = last1_q;
                    data1_d = rdata;
                    last1_d = last_in;
                end
            end
            default: ;
        endcase
    end

    // State machine; exits look at the post-pop beat so a burst closing this
    // cycle returns straight to IDLE instead of lingering in FLUSH.
    always_ff @(posedge rclk) begin
        if (!r_rst) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE:    if (enable) state_q <= RUN;
                RUN:     if (!enable) state_q <= (beat_d == '0) ? IDLE : FLUSH;
                FLUSH: begin
                    if (enable)              state_q <= RUN;
                    else if (beat_d == '0)   state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Datapath and counter registers.
    always_ff @(posedge rclk) begin
        if (!r_rst) begin
            beat_q     <= '0;
            occ_q      <= 2'd0;
            rd_count_q <= 16'd0;
            data0_q    <= '0;
            data1_q    <= '0;
            last0_q    <= 1'b0;
            last1_q    <= 1'b0;
        end else begin
            beat_q     <= beat_d;
            occ_q      <= occ_d;
            rd_count_q <= rd_count_d;
            data0_q    <= data0_d;
            data1_q    <= data1_d;
            last0_q    <= last0_d;
            last1_q    <= last1_d;
        end
    end

endmodule
